// File: rtl/slot_game_ctrl.sv
`default_nettype none
// slot_game_ctrl: credit-tracking sequencer for the three-reel slot datapath.
// Rev 1.0 - lever-triggered spin, staggered reel stops, grading and payout.
module slot_game_ctrl #(
   parameter int SPIN_CYCLES = 64,
   parameter int STOP_GAP    = 16,
   parameter int CREDIT_W    = 16,
   parameter int MAX_CREDITS = 9999,
   parameter int BET         = 1,
   parameter int PAY_PAIR    = 2,
   parameter int PAY_TRIPLE  = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                coin,
   input  logic                lever,
   input  logic [3:0]          digit_msb,
   input  logic [3:0]          digit_mid,
   input  logic [3:0]          digit_lsb,
   output logic [2:0]          reel_run,
   output logic [CREDIT_W-1:0] credits,
   output logic [1:0]          win_code,
   output logic                payout_valid,
   output logic [7:0]          payout_amt,
   output logic                busy,
   output logic                no_credit
);

   localparam int c_CNT_MAX = (SPIN_CYCLES > STOP_GAP) ? SPIN_CYCLES : STOP_GAP;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
   localparam int c_SUM_W   = ((CREDIT_W > 9) ? CREDIT_W : 9) + 1;

   localparam logic [c_CNT_W-1:0]  c_SPIN_LAST  = c_CNT_W'(SPIN_CYCLES - 1);
   localparam logic [c_CNT_W-1:0]  c_GAP_LAST   = c_CNT_W'(STOP_GAP - 1);
   localparam logic [CREDIT_W-1:0] c_BET        = CREDIT_W'(BET);
   localparam logic [CREDIT_W-1:0] c_MAX        = CREDIT_W'(MAX_CREDITS);
   localparam logic [c_SUM_W-1:0]  c_SUM_BET    = c_SUM_W'(BET);
   localparam logic [c_SUM_W-1:0]  c_SUM_MAX    = c_SUM_W'(MAX_CREDITS);
   localparam logic [7:0]          c_PAY_PAIR   = 8'(PAY_PAIR);
   localparam logic [7:0]          c_PAY_TRIPLE = 8'(PAY_TRIPLE);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SPIN    = 3'd1,
      S_STOP_A  = 3'd2,
      S_STOP_B  = 3'd3,
      S_EVAL    = 3'd4,
      S_PAY     = 3'd5,
      S_RELEASE = 3'd6
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [c_CNT_W-1:0]  r_cnt;
   logic                r_lever_q;
   logic [CREDIT_W-1:0] r_credits;
   logic [1:0]          r_win_code;
   logic [7:0]          r_payout_amt;
   logic                r_no_credit;

   logic                w_pull;
   logic                w_can_bet;
   logic                w_start;
   logic [1:0]          w_win_code;
   logic [7:0]          w_win_amt;
   logic [8:0]          w_add;
   logic [c_SUM_W-1:0]  w_sum;
   logic [CREDIT_W-1:0] w_credits_nxt;

   assign w_pull    = lever & ~r_lever_q;
   assign w_can_bet = (r_credits >= c_BET);
   assign w_start   = (r_state == S_IDLE) & w_pull & w_can_bet;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      reel_run     = 3'b000;
      payout_valid = 1'b0;
      busy         = (r_state != S_IDLE);
      case (r_state)
         S_IDLE:    if (w_start) w_next = S_SPIN;
         S_SPIN: begin
            reel_run = 3'b111;
            if (r_cnt == c_SPIN_LAST) w_next = S_STOP_A;
         end
         S_STOP_A: begin
            reel_run = 3'b011;
            if (r_cnt == c_GAP_LAST) w_next = S_STOP_B;
         end
         S_STOP_B: begin
            reel_run = 3'b001;
            if (r_cnt == c_GAP_LAST) w_next = S_EVAL;
         end
         S_EVAL:    w_next = S_PAY;
         S_PAY: begin
            payout_valid = 1'b1;
            w_next       = S_RELEASE;
         end
         S_RELEASE: if (!lever) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Dwell counter restarts on every state change; only the timed states count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_cnt <= '0;
      else if (w_next != r_state)
         r_cnt <= '0;
      else if ((r_state == S_SPIN) || (r_state == S_STOP_A) || (r_state == S_STOP_B))
         r_cnt <= r_cnt + 1'b1;
      else
         r_cnt <= '0;
   end

   always_comb begin
      w_win_code = 2'b00;
      w_win_amt  = 8'd0;
      if ((digit_msb == digit_mid) && (digit_mid == digit_lsb)) begin
         w_win_code = 2'b10;
         w_win_amt  = c_PAY_TRIPLE;
      end else if ((digit_msb == digit_mid) || (digit_mid == digit_lsb) ||
                   (digit_msb == digit_lsb)) begin
         w_win_code = 2'b01;
         w_win_amt  = c_PAY_PAIR;
      end
   end

   // Coin, payout and bet are folded into one signed-safe sum before saturating.
   always_comb begin
      w_add = {8'd0, coin} + ((r_state == S_PAY) ? {1'b0, r_payout_amt} : 9'd0);
      w_sum = {{(c_SUM_W - CREDIT_W){1'b0}}, r_credits} + c_SUM_W'(w_add)
              - (w_start ? c_SUM_BET : '0);
      w_credits_nxt = (w_sum > c_SUM_MAX) ? c_MAX : w_sum[CREDIT_W-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lever_q    <= 1'b1;
         r_credits    <= '0;
         r_win_code   <= 2'b00;
         r_payout_amt <= 8'd0;
         r_no_credit  <= 1'b0;
      end else begin
         r_lever_q   <= lever;
         r_credits   <= w_credits_nxt;
         r_no_credit <= (r_state == S_IDLE) & w_pull & ~w_can_bet;
         if (w_start) begin
            r_win_code   <= 2'b00;
            r_payout_amt <= 8'd0;
         end else if (r_state == S_EVAL) begin
            r_win_code   <= w_win_code;
            r_payout_amt <= w_win_amt;
         end
      end
   end

   assign credits    = r_credits;
   assign win_code   = r_win_code;
   assign payout_amt = r_payout_amt;
   assign no_credit  = r_no_credit;

endmodule
`default_nettype wire

// File: tb/tb_slot_game_ctrl.sv
`default_nettype none
// tb_slot_game_ctrl: directed-vector bench for the slot sequencer.
// Rev 1.0 - SPIN_CYCLES=4, STOP_GAP=2.
module tb_slot_game_ctrl;

   localparam int c_CW  = 16;
   localparam int c_MAX = 9999;

   logic            clk = 1'b0;
   logic            reset;
   logic            coin;
   logic            lever;
   logic [3:0]      digit_msb;
   logic [3:0]      digit_mid;
   logic [3:0]      digit_lsb;
   logic [2:0]      reel_run;
   logic [c_CW-1:0] credits;
   logic [1:0]      win_code;
   logic            payout_valid;
   logic [7:0]      payout_amt;
   logic            busy;
   logic            no_credit;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   slot_game_ctrl #(
      .SPIN_CYCLES (4),
      .STOP_GAP    (2),
      .CREDIT_W    (c_CW),
      .MAX_CREDITS (c_MAX),
      .BET         (1),
      .PAY_PAIR    (2),
      .PAY_TRIPLE  (10)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .coin         (coin),
      .lever        (lever),
      .digit_msb    (digit_msb),
      .digit_mid    (digit_mid),
      .digit_lsb    (digit_lsb),
      .reel_run     (reel_run),
      .credits      (credits),
      .win_code     (win_code),
      .payout_valid (payout_valid),
      .payout_amt   (payout_amt),
      .busy         (busy),
      .no_credit    (no_credit)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One complete game: pull, reel sequence, grading, payout and lever release.
   task automatic spin(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [1:0] ew, input logic [7:0] ea, input int c0,
                       input bit hold, input bit cpull, input bit cpay);
      int e_entry;
      int e_final;
      e_entry = c0 + int'(cpull) - 1;
      e_final = e_entry + int'(ea) + int'(cpay);
      if (e_final > c_MAX) e_final = c_MAX;
      digit_msb = a;
      digit_mid = b;
      digit_lsb = c;
      lever = 1'b1;
      coin  = cpull;
      step(1);
      coin = 1'b0;
      check("entry_reel", reel_run, 3'b111);
      check("entry_credits", credits, e_entry);
      check("entry_win", win_code, 2'b00);
      check("entry_amt", payout_amt, 8'd0);
      if (!hold) lever = 1'b0;
      for (int i = 1; i < 4; i++) begin
         step(1);
         check("spin_reel", reel_run, 3'b111);
      end
      for (int i = 0; i < 2; i++) begin
         step(1);
         check("stop_a_reel", reel_run, 3'b011);
      end
      for (int i = 0; i < 2; i++) begin
         step(1);
         check("stop_b_reel", reel_run, 3'b001);
      end
      step(1);
      check("eval_reel", reel_run, 3'b000);
      check("eval_pv", payout_valid, 1'b0);
      check("eval_busy", busy, 1'b1);
      step(1);
      check("pay_pv", payout_valid, 1'b1);
      check("pay_win", win_code, ew);
      check("pay_amt", payout_amt, ea);
      check("pay_credits_before", credits, e_entry);
      coin = cpay;
      step(1);
      coin = 1'b0;
      check("post_pay_credits", credits, e_final);
      check("post_pay_pv", payout_valid, 1'b0);
      check("release_busy", busy, 1'b1);
      check("held_win", win_code, ew);
      if (hold) begin
         step(3);
         check("hold_busy", busy, 1'b1);
         check("hold_reel", reel_run, 3'b000);
         check("hold_credits", credits, e_final);
         lever = 1'b0;
      end
      step(1);
      check("idle_busy", busy, 1'b0);
      check("idle_amt", payout_amt, ea);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      coin      = 1'b0;
      lever     = 1'b0;
      digit_msb = 4'd0;
      digit_mid = 4'd0;
      digit_lsb = 4'd0;
      step(2);
      check("rst_credits", credits, 0);
      check("rst_reel", reel_run, 3'b000);
      check("rst_busy", busy, 1'b0);
      check("rst_win", win_code, 2'b00);
      check("rst_amt", payout_amt, 8'd0);
      check("rst_pv", payout_valid, 1'b0);
      check("rst_nc", no_credit, 1'b0);
      reset = 1'b0;
      step(2);

      // Pull with no credits.
      lever = 1'b1;
      step(1);
      check("nc_pulse", no_credit, 1'b1);
      check("nc_busy", busy, 1'b0);
      step(1);
      check("nc_single", no_credit, 1'b0);
      check("nc_busy2", busy, 1'b0);
      check("nc_credits", credits, 0);
      lever = 1'b0;
      step(1);

      for (int i = 0; i < 3; i++) begin
         coin = 1'b1;
         step(1);
         coin = 1'b0;
         step(1);
      end
      check("three_coins", credits, 3);

      spin(4'd7, 4'd7, 4'd7, 2'b10, 8'd10, 3, 1'b0, 1'b0, 1'b0);
      check("triple_total", credits, 12);
      spin(4'd3, 4'd5, 4'd3, 2'b01, 8'd2, 12, 1'b0, 1'b0, 1'b0);
      spin(4'd1, 4'd2, 4'd3, 2'b00, 8'd0, 13, 1'b0, 1'b0, 1'b0);
      spin(4'd4, 4'd4, 4'd9, 2'b01, 8'd2, 12, 1'b1, 1'b0, 1'b0);
      spin(4'd0, 4'd0, 4'd0, 2'b10, 8'd10, 13, 1'b0, 1'b0, 1'b0);
      check("pre_sat_credits", credits, 22);

      // Coin held high past the ceiling.
      coin = 1'b1;
      step(c_MAX - 22 + 5);
      coin = 1'b0;
      check("coin_sat", credits, c_MAX);
      spin(4'd5, 4'd5, 4'd5, 2'b10, 8'd10, c_MAX, 1'b0, 1'b0, 1'b1);
      check("pay_sat", credits, c_MAX);

      // Reset in the middle of STOP_A with the lever still held.
      lever = 1'b1;
      step(1);
      check("abort_spin_reel", reel_run, 3'b111);
      step(4);
      check("abort_stop_a_reel", reel_run, 3'b011);
      reset = 1'b1;
      #1;
      check("abort_reel", reel_run, 3'b000);
      check("abort_credits", credits, 0);
      check("abort_busy", busy, 1'b0);
      step(1);
      reset = 1'b0;
      step(3);
      check("held_no_spin_busy", busy, 1'b0);
      check("held_no_spin_reel", reel_run, 3'b000);
      check("held_no_nc", no_credit, 1'b0);
      lever = 1'b0;
      step(1);

      coin = 1'b1;
      step(1);
      coin = 1'b0;
      check("one_credit", credits, 1);
      spin(4'd1, 4'd2, 4'd3, 2'b00, 8'd0, 1, 1'b0, 1'b1, 1'b0);
      spin(4'd2, 4'd4, 4'd6, 2'b00, 8'd0, 1, 1'b0, 1'b0, 1'b0);
      check("drained", credits, 0);
      lever = 1'b1;
      step(1);
      check("nc_again", no_credit, 1'b1);
      check("nc_again_busy", busy, 1'b0);
      lever = 1'b0;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
